// File: rtl/snake_dir_queue.sv
// Purpose : turns one-cycle direction-key release pulses into the snake's movement
//           direction, queueing up to DEPTH filtered turns and applying one per game tick.
// Latency : pulse -> queued at next edge; tick -> dir/dir_changed updated at next edge.
// Backpressure: none upstream; a valid turn arriving while full (and not popping) is
//           dropped and latches the sticky overflow flag.
// Ports   : clk/rst (sync, active-high); up_p/down_p/left_p/right_p key pulses;
//           tick pop strobe; flush game restart; dir, dir_changed, count, overflow status.
// Direction encoding: 00 up, 01 down, 10 left, 11 right (reversal = flip of bit 0).
module snake_dir_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_p,
    input  logic                       down_p,
    input  logic                       left_p,
    input  logic                       right_p,
    input  logic                       tick,
    input  logic                       flush,
    output logic [1:0]                 dir,
    output logic                       dir_changed,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_changed_q, dir_changed_d;
    logic             overflow_q, overflow_d;

    logic [2:0] n_pulses;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       cand_ok;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        n_pulses = {2'b00, up_p} + {2'b00, down_p} + {2'b00, left_p} + {2'b00, right_p};
        cand = 2'b00;
        if (down_p)  cand = 2'b01;
        if (left_p)  cand = 2'b10;
        if (right_p) cand = 2'b11;

        // Filter against the direction the snake will have when this turn is applied:
        // the most recently queued turn, or the live direction when nothing is queued.
        ref_dir = (count_q != '0) ? mem_q[tail_q - PTR_W'(1)] : dir_q;
        cand_ok = (n_pulses == 3'd1) && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));

        do_pop  = tick && (count_q != '0);
        // A full queue still accepts when the same cycle frees a slot.
        do_push = cand_ok && ((count_q < CNT_W'(DEPTH)) || do_pop);

        mem_d         = mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        dir_d         = dir_q;
        dir_changed_d = do_pop;
        overflow_d    = overflow_q | (cand_ok && !do_push);

        if (do_pop) begin
            dir_d  = mem_q[head_q];
            head_d = head_q + PTR_W'(1);
        end
        if (do_push) begin
            mem_d[tail_q] = cand;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);

        // Restart wins over any same-cycle push or pop.
        if (flush) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            dir_d         = INIT_DIR;
            dir_changed_d = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            dir_q         <= INIT_DIR;
            dir_changed_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read between tail and head.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    assign dir         = dir_q;
    assign dir_changed = dir_changed_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_snake_dir_queue.sv
// Purpose : randomized and directed checking of snake_dir_queue against a queue-based model.
// Latency : inputs driven after a falling edge, outputs compared at the next falling edge.
// Backpressure: n/a (bench).
module tb_snake_dir_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, up_p, down_p, left_p, right_p, tick, flush;
    logic [1:0] dir;
    logic       dir_changed;
    logic [2:0] count;
    logic       overflow;

    snake_dir_queue #(.DEPTH(DEPTH), .INIT_DIR(2'b11)) dut (
        .clk(clk), .rst(rst),
        .up_p(up_p), .down_p(down_p), .left_p(left_p), .right_p(right_p),
        .tick(tick), .flush(flush),
        .dir(dir), .dir_changed(dir_changed), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [1:0] m_q[$];
    logic [1:0] m_dir = 2'b11;
    logic       m_dc  = 1'b0;
    logic       m_ov  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the behavioural rules.
    task automatic model_step(input logic r, input logic u, input logic d, input logic l,
                              input logic rt, input logic t, input logic f);
        int         npul;
        logic [1:0] c;
        logic [1:0] rf;
        logic       ok, pop;
        if (r || f) begin
            m_q.delete();
            m_dir = 2'b11;
            m_dc  = 1'b0;
            m_ov  = 1'b0;
            return;
        end
        npul = int'(u) + int'(d) + int'(l) + int'(rt);
        c    = u ? 2'b00 : d ? 2'b01 : l ? 2'b10 : 2'b11;
        rf   = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
        ok   = (npul == 1) && (c != rf) && (c != {rf[1], ~rf[0]});
        pop  = t && (m_q.size() > 0);
        if (ok && !(m_q.size() < DEPTH || pop)) begin
            m_ov = 1'b1;
            ok   = 1'b0;
        end
        if (pop) m_dir = m_q.pop_front();
        if (ok) m_q.push_back(c);
        m_dc = pop;
    endtask

    // One clock: drive inputs, update model, compare at the next falling edge.
    task automatic step(input logic r, input logic u, input logic d, input logic l,
                        input logic rt, input logic t, input logic f);
        rst = r; up_p = u; down_p = d; left_p = l; right_p = rt; tick = t; flush = f;
        model_step(r, u, d, l, rt, t, f);
        @(negedge clk);
        check("dir", 32'(dir), 32'(m_dir));
        check("count", 32'(count), 32'(m_q.size()));
        check("dir_changed", 32'(dir_changed), 32'(m_dc));
        check("overflow", 32'(overflow), 32'(m_ov));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; up_p = 0; down_p = 0; left_p = 0; right_p = 0; tick = 0; flush = 0;
        @(negedge clk);

        // 1: reset state
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        check("t1_dir", 32'(dir), 32'h3);
        check("t1_count", 32'(count), 32'h0);
        check("t1_ovf", 32'(overflow), 32'h0);
        check("t1_dc", 32'(dir_changed), 32'h0);

        // 2: single turn then tick
        step(0, 1, 0, 0, 0, 0, 0);
        check("t2_count1", 32'(count), 32'h1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_count0", 32'(count), 32'h0);
        check("t2_dir", 32'(dir), 32'h0);
        check("t2_dc_hi", 32'(dir_changed), 32'h1);
        idle();
        check("t2_dc_lo", 32'(dir_changed), 32'h0);

        // 3: reversal and no-op from right
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t3_rev", 32'(count), 32'h0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("t3_noop", 32'(count), 32'h0);

        // 4: three turns filtered against queue tail, applied in order
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("t4_count", 32'(count), 32'h3);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t4_dir0", 32'(dir), 32'h0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t4_dir1", 32'(dir), 32'h2);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t4_dir2", 32'(dir), 32'h1);

        // 5: overflow when full, and full+tick accepted
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("t5_full", 32'(count), 32'h4);
        check("t5_ovf", 32'(overflow), 32'h1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t5_flush_ovf", 32'(overflow), 32'h0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        check("t5_full_tick", 32'(count), 32'h4);
        check("t5_no_ovf", 32'(overflow), 32'h0);

        // 6: ambiguous pulses ignored; flush overrides tick
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0, 0, 0);
        check("t6_ambig", 32'(count), 32'h0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t6_count2", 32'(count), 32'h2);
        step(0, 0, 0, 0, 0, 1, 1);
        check("t6_flush_cnt", 32'(count), 32'h0);
        check("t6_flush_dir", 32'(dir), 32'h3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] p;
            int         sel;
            sel = $urandom_range(0, 99);
            if (sel < 55)      p = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 65) p = 4'($urandom_range(0, 15));
            else               p = 4'b0000;
            step(($urandom_range(0, 199) == 0), p[3], p[2], p[1], p[0],
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
